// File: rtl/mem_write_checker_pkg.sv
// Shared definitions for the data-memory write checker.
//   state_e  : checker FSM states
//   FC_*     : fail_code encodings reported on the fail_code output
package mem_write_checker_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StPass = 2'b10,
        StFail = 2'b11
    } state_e;

    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_MISMATCH = 2'b01;
    localparam logic [1:0] FC_TIMEOUT  = 2'b10;

endpackage

// File: rtl/write_compare.sv
// Selects expected entry idx from the flat expected buses and compares it
// against the current store.
//   exp_addr/exp_data : flat expected lists, entry k at [k*W +: W]
//   idx               : entry to compare against (match count so far)
//   dataadr/writedata : observed store
//   hit               : address and data both equal the selected entry
//   ignorable         : store targets the tolerated scratch address
module write_compare #(
    parameter int unsigned    N_EXP    = 1,
    parameter int unsigned    AW       = 32,
    parameter int unsigned    DW       = 32,
    parameter logic [AW-1:0]  IGN_ADDR = AW'(80),
    parameter bit             IGN_EN   = 1'b1
) (
    input  logic [N_EXP*AW-1:0] exp_addr,
    input  logic [N_EXP*DW-1:0] exp_data,
    input  logic [4:0]          idx,
    input  logic [AW-1:0]       dataadr,
    input  logic [DW-1:0]       writedata,
    output logic                hit,
    output logic                ignorable
);

    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int unsigned k = 0; k < N_EXP; k++) begin
            if (idx == 5'(k)) begin
                sel_addr = exp_addr[k*AW +: AW];
                sel_data = exp_data[k*DW +: DW];
            end
        end
    end

    // Case equality so that any X/Z on the store bus never counts as a hit.
    always_comb begin
        hit       = (dataadr === sel_addr) && (writedata === sel_data);
        ignorable = IGN_EN && (dataadr === IGN_ADDR);
    end

endmodule

// File: rtl/mem_write_checker.sv
// Monitors the core's data-memory write port and checks the store stream
// against an ordered list of expected (address, data) pairs.
//   clk, reset (async, active-low), start (arm pulse)
//   memwrite/dataadr/writedata : observed store port
//   exp_addr/exp_data          : flat expected lists
//   done, pass, fail_code      : verdict (sticky until reset)
//   match_cnt                  : expected entries matched so far
//   err_addr/err_data          : offending store on a mismatch
module mem_write_checker
    import mem_write_checker_pkg::*;
#(
    parameter int unsigned    N_EXP    = 1,
    parameter int unsigned    AW       = 32,
    parameter int unsigned    DW       = 32,
    parameter int unsigned    TIMEOUT  = 30,
    parameter logic [AW-1:0]  IGN_ADDR = AW'(80),
    parameter bit             IGN_EN   = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                memwrite,
    input  logic [AW-1:0]       dataadr,
    input  logic [DW-1:0]       writedata,
    input  logic [N_EXP*AW-1:0] exp_addr,
    input  logic [N_EXP*DW-1:0] exp_data,
    output logic                done,
    output logic                pass,
    output logic [1:0]          fail_code,
    output logic [4:0]          match_cnt,
    output logic [AW-1:0]       err_addr,
    output logic [DW-1:0]       err_data
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    state_e        state_q, state_d;
    logic [4:0]    match_q, match_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    fc_q, fc_d;
    logic [AW-1:0] err_addr_q, err_addr_d;
    logic [DW-1:0] err_data_q, err_data_d;
    logic          done_q, pass_q;
    logic          hit, ignorable, timeout;

    write_compare #(
        .N_EXP    (N_EXP),
        .AW       (AW),
        .DW       (DW),
        .IGN_ADDR (IGN_ADDR),
        .IGN_EN   (IGN_EN)
    ) u_cmp (
        .exp_addr  (exp_addr),
        .exp_data  (exp_data),
        .idx       (match_q),
        .dataadr   (dataadr),
        .writedata (writedata),
        .hit       (hit),
        .ignorable (ignorable)
    );

    // This RUN cycle is the TIMEOUT-th one since entry.
    assign timeout = (cnt_q >= CW'(TIMEOUT - 1));

    always_comb begin
        state_d    = state_q;
        match_d    = match_q;
        cnt_d      = cnt_q;
        fc_d       = fc_q;
        err_addr_d = err_addr_q;
        err_data_d = err_data_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    match_d = '0;
                    cnt_d   = '0;
                end
            end
            StRun: begin
                if (cnt_q < CW'(TIMEOUT)) begin
                    cnt_d = cnt_q + CW'(1);
                end
                // Priority: completing match > mismatch > timeout.
                if (memwrite && hit) begin
                    match_d = match_q + 5'd1;
                    if (match_q == 5'(N_EXP - 1)) begin
                        state_d = StPass;
                    end else if (timeout) begin
                        state_d = StFail;
                        fc_d    = FC_TIMEOUT;
                    end
                end else if (memwrite && !ignorable) begin
                    state_d    = StFail;
                    fc_d       = FC_MISMATCH;
                    err_addr_d = dataadr;
                    err_data_d = writedata;
                end else if (timeout) begin
                    state_d = StFail;
                    fc_d    = FC_TIMEOUT;
                end
            end
            StPass, StFail: begin
                // Sticky until reset.
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            match_q    <= '0;
            cnt_q      <= '0;
            fc_q       <= FC_NONE;
            err_addr_q <= '0;
            err_data_q <= '0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            match_q    <= match_d;
            cnt_q      <= cnt_d;
            fc_q       <= fc_d;
            err_addr_q <= err_addr_d;
            err_data_q <= err_data_d;
            done_q     <= (state_d == StPass) || (state_d == StFail);
            pass_q     <= (state_d == StPass);
        end
    end

    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_code = fc_q;
    assign match_cnt = match_q;
    assign err_addr  = err_addr_q;
    assign err_data  = err_data_q;

endmodule

// File: tb/tb_mem_write_checker.sv
module tb_mem_write_checker;

    typedef struct packed {
        logic        done;
        logic        pass;
        logic [1:0]  fc;
        logic [4:0]  mc;
        logic [31:0] ea;
        logic [31:0] ed;
    } obs_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;

    // dut1: N_EXP=1, exp (84,7); dut3: N_EXP=3; dut0: N_EXP=1 with IGN_EN=0
    logic [31:0] exp_addr1, exp_data1, exp_addr0, exp_data0;
    logic [95:0] exp_addr3, exp_data3;

    logic        done1, pass1, done3, pass3, done0, pass0;
    logic [1:0]  fc1, fc3, fc0;
    logic [4:0]  mc1, mc3, mc0;
    logic [31:0] ea1, ed1, ea3, ed3, ea0, ed0;

    obs_t obs, obs1, obs3, obs0;
    int   sel;
    obs_t sb[$];
    int   checks;
    int   errors;

    assign exp_addr1 = 32'd84;
    assign exp_data1 = 32'd7;
    assign exp_addr0 = 32'd84;
    assign exp_data0 = 32'd7;
    assign exp_addr3 = {32'd84, 32'd8, 32'd4};
    assign exp_data3 = {32'd7, 32'd2, 32'd1};

    mem_write_checker #(.N_EXP(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .memwrite(memwrite),
        .dataadr(dataadr), .writedata(writedata),
        .exp_addr(exp_addr1), .exp_data(exp_data1),
        .done(done1), .pass(pass1), .fail_code(fc1), .match_cnt(mc1),
        .err_addr(ea1), .err_data(ed1)
    );

    mem_write_checker #(.N_EXP(3)) dut3 (
        .clk(clk), .reset(reset), .start(start), .memwrite(memwrite),
        .dataadr(dataadr), .writedata(writedata),
        .exp_addr(exp_addr3), .exp_data(exp_data3),
        .done(done3), .pass(pass3), .fail_code(fc3), .match_cnt(mc3),
        .err_addr(ea3), .err_data(ed3)
    );

    mem_write_checker #(.N_EXP(1), .IGN_EN(1'b0)) dut0 (
        .clk(clk), .reset(reset), .start(start), .memwrite(memwrite),
        .dataadr(dataadr), .writedata(writedata),
        .exp_addr(exp_addr0), .exp_data(exp_data0),
        .done(done0), .pass(pass0), .fail_code(fc0), .match_cnt(mc0),
        .err_addr(ea0), .err_data(ed0)
    );

    assign obs1 = {done1, pass1, fc1, mc1, ea1, ed1};
    assign obs3 = {done3, pass3, fc3, mc3, ea3, ed3};
    assign obs0 = {done0, pass0, fc0, mc0, ea0, ed0};

    always_comb begin
        case (sel)
            1:       obs = obs3;
            2:       obs = obs0;
            default: obs = obs1;
        endcase
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(1);
    endtask

    task automatic arm();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        memwrite  = 1'b1;
        dataadr   = a;
        writedata = d;
        tick(1);
        memwrite  = 1'b0;
        dataadr   = '0;
        writedata = '0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (obs.done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        if (obs.done === 1'b1) ok = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(2);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            checks++;
            if (obs !== '0) begin
                errors++;
                $display("FAIL reset_state dut%0d got %h want %h", s, obs, obs_t'(0));
            end
        end
        reset = 1'b1;
        tick(1);
    endtask

    task automatic test_ignore_then_match();
        obs_t e;
        bit   ok;
        sel = 0;
        do_reset();
        sb.push_back('{done: 1'b1, pass: 1'b1, fc: 2'b00, mc: 5'd1, ea: 32'd0, ed: 32'd0});
        arm();
        store(32'd80, 32'd3);
        checks++;
        if (obs.done !== 1'b0 || obs.mc !== 5'd0) begin
            errors++;
            $display("FAIL ignore_no_effect got done=%b mc=%0d want done=0 mc=0", obs.done, obs.mc);
        end
        store(32'd84, 32'd7);
        wait_done(5, ok);
        e = sb.pop_front();
        checks++;
        if (!ok || obs !== e) begin
            errors++;
            $display("FAIL ignore_then_match got %h want %h", obs, e);
        end
    endtask

    task automatic test_mismatch();
        obs_t e;
        bit   ok;
        sel = 0;
        do_reset();
        sb.push_back('{done: 1'b1, pass: 1'b0, fc: 2'b01, mc: 5'd0, ea: 32'd84, ed: 32'd6});
        arm();
        store(32'd84, 32'd6);
        wait_done(5, ok);
        e = sb.pop_front();
        checks++;
        if (!ok || obs !== e) begin
            errors++;
            $display("FAIL data_mismatch got %h want %h", obs, e);
        end
    endtask

    task automatic test_in_order_gaps();
        obs_t e;
        bit   ok;
        sel = 1;
        do_reset();
        sb.push_back('{done: 1'b1, pass: 1'b1, fc: 2'b00, mc: 5'd3, ea: 32'd0, ed: 32'd0});
        arm();
        tick(2);
        store(32'd4, 32'd1);
        checks++;
        if (obs.mc !== 5'd1 || obs.done !== 1'b0) begin
            errors++;
            $display("FAIL partial_match got mc=%0d done=%b want mc=1 done=0", obs.mc, obs.done);
        end
        tick(3);
        store(32'd8, 32'd2);
        tick(1);
        store(32'd84, 32'd7);
        wait_done(5, ok);
        e = sb.pop_front();
        checks++;
        if (!ok || obs !== e) begin
            errors++;
            $display("FAIL in_order_gaps got %h want %h", obs, e);
        end
    endtask

    task automatic test_swapped();
        obs_t e;
        bit   ok;
        sel = 1;
        do_reset();
        sb.push_back('{done: 1'b1, pass: 1'b0, fc: 2'b01, mc: 5'd0, ea: 32'd8, ed: 32'd2});
        arm();
        store(32'd8, 32'd2);
        store(32'd4, 32'd1);
        wait_done(5, ok);
        e = sb.pop_front();
        checks++;
        if (!ok || obs !== e) begin
            errors++;
            $display("FAIL swapped_order got %h want %h", obs, e);
        end
    endtask

    task automatic test_back_to_back();
        obs_t e;
        bit   ok;
        sel = 1;
        do_reset();
        sb.push_back('{done: 1'b1, pass: 1'b1, fc: 2'b00, mc: 5'd3, ea: 32'd0, ed: 32'd0});
        arm();
        store(32'd4, 32'd1);
        store(32'd80, 32'd9);
        store(32'd8, 32'd2);
        store(32'd84, 32'd7);
        wait_done(5, ok);
        e = sb.pop_front();
        checks++;
        if (!ok || obs !== e) begin
            errors++;
            $display("FAIL back_to_back got %h want %h", obs, e);
        end
    endtask

    task automatic test_timeout();
        obs_t e;
        sel = 0;
        do_reset();
        sb.push_back('{done: 1'b1, pass: 1'b0, fc: 2'b10, mc: 5'd0, ea: 32'd0, ed: 32'd0});
        arm();
        tick(29);
        checks++;
        if (obs.done !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early got done=%b want 0 at cycle 29", obs.done);
        end
        tick(1);
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL timeout_cycle30 got %h want %h", obs, e);
        end
    endtask

    task automatic test_timeout_match();
        obs_t e;
        sel = 0;
        do_reset();
        sb.push_back('{done: 1'b1, pass: 1'b1, fc: 2'b00, mc: 5'd1, ea: 32'd0, ed: 32'd0});
        arm();
        tick(29);
        store(32'd84, 32'd7);
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL match_beats_timeout got %h want %h", obs, e);
        end
    endtask

    task automatic test_no_ignore_sticky();
        obs_t e;
        bit   ok;
        sel = 2;
        do_reset();
        sb.push_back('{done: 1'b1, pass: 1'b0, fc: 2'b01, mc: 5'd0, ea: 32'd80, ed: 32'd3});
        arm();
        store(32'd80, 32'd3);
        wait_done(5, ok);
        e = sb.pop_front();
        checks++;
        if (!ok || obs !== e) begin
            errors++;
            $display("FAIL ign_disabled got %h want %h", obs, e);
        end
        // start and a matching store after FAIL must not change anything
        arm();
        store(32'd84, 32'd7);
        tick(2);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL fail_sticky got %h want %h", obs, e);
        end
    endtask

    task automatic test_mid_reset();
        obs_t e;
        bit   ok;
        sel = 1;
        do_reset();
        arm();
        store(32'd4, 32'd1);
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL async_reset_abort got %h want %h", obs, obs_t'(0));
        end
        tick(1);
        reset = 1'b1;
        tick(1);
        sb.push_back('{done: 1'b1, pass: 1'b1, fc: 2'b00, mc: 5'd3, ea: 32'd0, ed: 32'd0});
        arm();
        store(32'd4, 32'd1);
        store(32'd8, 32'd2);
        store(32'd84, 32'd7);
        wait_done(5, ok);
        e = sb.pop_front();
        checks++;
        if (!ok || obs !== e) begin
            errors++;
            $display("FAIL rearm_after_reset got %h want %h", obs, e);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        sel       = 0;
        reset     = 1'b0;
        start     = 1'b0;
        memwrite  = 1'b0;
        dataadr   = '0;
        writedata = '0;

        test_reset();
        test_ignore_then_match();
        test_mismatch();
        test_in_order_gaps();
        test_swapped();
        test_back_to_back();
        test_timeout();
        test_timeout_match();
        test_no_ignore_sticky();
        test_mid_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
